// File: rtl/data_memory_ctrl.sv
// Single-port data memory for the MEM stage: valid/ready request port, byte-strobed
// writes, registered one-cycle response, range checking and a clear/preload sequencer.
module data_memory_ctrl #(
  parameter int DATA_W        = 16,
  parameter int DEPTH         = 64,
  parameter int ADDR_W        = 16,
  parameter int PRELOAD_ADDR0 = 17,
  parameter int PRELOAD_VAL0  = 56,
  parameter int PRELOAD_ADDR1 = 15,
  parameter int PRELOAD_VAL1  = 65
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PA0      = ADDR_W'(PRELOAD_ADDR0);
  localparam logic [ADDR_W-1:0] PA1      = ADDR_W'(PRELOAD_ADDR1);
  localparam logic [DATA_W-1:0] PV0      = DATA_W'(PRELOAD_VAL0);
  localparam logic [DATA_W-1:0] PV1      = DATA_W'(PRELOAD_VAL1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [BE_W-1:0]     mem_be;
  logic [DATA_W-1:0]   mem_wdata;
  logic [IDX_W-1:0]    rd_idx;
  logic                in_range;

  assign rd_idx   = req_addr[IDX_W-1:0];
  assign in_range = ({1'b0, req_addr} < DEPTH_X);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    req_ready   = 1'b0;
    mem_we      = 1'b0;
    mem_idx     = rd_idx;
    mem_be      = '0;
    mem_wdata   = req_wdata;

    unique case (state_q)
      INIT: begin
        // Sweep the whole array once, planting the two preload words on the way.
        mem_we  = 1'b1;
        mem_idx = cnt_q[IDX_W-1:0];
        mem_be  = '1;
        if (cnt_q == PA0)      mem_wdata = PV0;
        else if (cnt_q == PA1) mem_wdata = PV1;
        else                   mem_wdata = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            rsp_valid_d = 1'b1;
            if (!in_range) begin
              rsp_err_d = 1'b1;
            end else if (req_we) begin
              mem_we = 1'b1;
              mem_be = req_be;
            end else begin
              rsp_rdata_d = mem[rd_idx];
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // The array itself is never reset; the INIT sweep rewrites every word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = (state_q == IDLE);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: randomized and directed requests checked against an
// array model of the memory contents and response rules.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int errors = 0;
  int checks = 0;
  logic [15:0] model [64];

  data_memory_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_model();
    for (int i = 0; i < 64; i++) model[i] = 16'h0000;
    model[17] = 16'd56;
    model[15] = 16'd65;
  endtask

  // Initialisation window: 63 cycles of nothing, init_done and ready on the 64th.
  task automatic wait_init(input string name);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'd17;
    for (int i = 1; i <= 64; i++) begin
      tick();
      checks++;
      if (i < 64) begin
        if ({req_ready, rsp_valid, init_done} !== 3'b000) begin
          errors++;
          $display("FAIL %s_cycle%0d: ready/rsp_valid/init_done=%b expected 000",
                   name, i, {req_ready, rsp_valid, init_done});
        end
      end else begin
        if ({req_ready, rsp_valid, init_done} !== 3'b101) begin
          errors++;
          $display("FAIL %s_cycle%0d: ready/rsp_valid/init_done=%b expected 101",
                   name, i, {req_ready, rsp_valid, init_done});
        end
        req_valid = 1'b0;
      end
    end
    init_model();
  endtask

  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be, input string name);
    logic [15:0] exp_d;
    logic        exp_e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    exp_e = (addr >= 16'd64);
    exp_d = (!we && !exp_e) ? model[addr[5:0]] : 16'h0000;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b expected 1", name, req_ready);
    end
    tick();
    if (we && !exp_e) begin
      for (int b = 0; b < 2; b++)
        if (be[b]) model[addr[5:0]][8*b +: 8] = wdata[8*b +: 8];
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, exp_e, exp_d}) begin
      errors++;
      $display("FAIL %s_rsp: valid=%b err=%b rdata=%h expected valid=1 err=%b rdata=%h",
               name, rsp_valid, rsp_err, rsp_rdata, exp_e, exp_d);
    end
    req_valid = 1'b0;
  endtask

  task automatic idle_gap(input string name);
    req_valid = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 18'h0) begin
      errors++;
      $display("FAIL %s_idle: valid=%b err=%b rdata=%h expected all zero",
               name, rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    clear_req = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'd0;
    req_wdata = 16'd0;
    req_be    = 2'b00;
    tick();
    tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, init_done, rsp_rdata} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b err=%b done=%b rdata=%h expected all zero",
               req_ready, rsp_valid, rsp_err, init_done, rsp_rdata);
    end
    rst = 1'b1;
    wait_init("init_after_reset");
  endtask

  task automatic test_init_contents();
    issue(1'b0, 16'd17, 16'h0, 2'b00, "rd17");
    issue(1'b0, 16'd15, 16'h0, 2'b00, "rd15");
    issue(1'b0, 16'd0,  16'h0, 2'b00, "rd0");
    issue(1'b0, 16'd63, 16'h0, 2'b00, "rd63");
    idle_gap("after_init_reads");
  endtask

  task automatic test_byte_enable();
    issue(1'b1, 16'd3, 16'h1234, 2'b11, "be_wr_full");
    issue(1'b1, 16'd3, 16'hABCD, 2'b01, "be_wr_lo");
    issue(1'b0, 16'd3, 16'h0,    2'b00, "be_rd_lo");
    issue(1'b1, 16'd3, 16'h1234, 2'b11, "be_wr_full2");
    issue(1'b1, 16'd3, 16'hABCD, 2'b10, "be_wr_hi");
    issue(1'b0, 16'd3, 16'h0,    2'b00, "be_rd_hi");
    issue(1'b1, 16'd3, 16'hFFFF, 2'b00, "be_wr_none");
    issue(1'b0, 16'd3, 16'h0,    2'b00, "be_rd_none");
    idle_gap("after_be");
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 16'd5, 16'h00AA, 2'b11, "raw_wr5");
    issue(1'b0, 16'd5, 16'h0,    2'b00, "raw_rd5");
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 79)), 16'($urandom),
            2'($urandom_range(0, 3)), "rand");
    end
    idle_gap("after_stream");
  endtask

  task automatic test_out_of_range();
    issue(1'b0, 16'd64,  16'h0,    2'b00, "oor_rd64");
    issue(1'b1, 16'd100, 16'hFFFF, 2'b11, "oor_wr100");
    for (int a = 0; a < 64; a++) issue(1'b0, 16'(a), 16'h0, 2'b00, "sweep");
    idle_gap("after_oor");
  endtask

  task automatic test_clear();
    issue(1'b1, 16'd10, 16'h5555, 2'b11, "clr_wr10");
    clear_req = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'd10;
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b01) begin
      errors++;
      $display("FAIL clear_cycle: ready=%b rsp_valid=%b expected ready=0 rsp_valid=1",
               req_ready, rsp_valid);
    end
    tick();
    clear_req = 1'b0;
    checks++;
    if ({init_done, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL clear_entry: init_done=%b rsp_valid=%b expected 0 0", init_done, rsp_valid);
    end
    wait_init("init_after_clear");
    issue(1'b0, 16'd10, 16'h0, 2'b00, "clr_rd10");
    issue(1'b0, 16'd17, 16'h0, 2'b00, "clr_rd17");
    idle_gap("after_clear");
  endtask

  task automatic test_async_reset();
    issue(1'b0, 16'd17, 16'h0, 2'b00, "ar_rd17");
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, init_done, rsp_rdata} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset: ready=%b valid=%b err=%b done=%b rdata=%h expected all zero",
               req_ready, rsp_valid, rsp_err, init_done, rsp_rdata);
    end
    tick();
    rst = 1'b1;
    wait_init("init_after_async");
    issue(1'b0, 16'd15, 16'h0, 2'b00, "ar_rd15");
    issue(1'b0, 16'd17, 16'h0, 2'b00, "ar_rd17b");
    idle_gap("after_async");
  endtask

  initial begin
    init_model();
    test_reset();
    test_init_contents();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
